// File: rtl/commit_trace_fifo_if.sv
// Retirement-event and trace-drain signal bundle for commit_trace_fifo.
// The slave side is the FIFO; the master side is the core/consumer environment.
interface commit_trace_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          w_grf_we;
    logic [4:0]    w_grf_addr;
    logic [31:0]   w_grf_wdata;
    logic [31:0]   w_inst_addr;
    logic [31:0]   m_data_addr;
    logic [31:0]   m_data_wdata;
    logic [3:0]    m_data_byteen;
    logic [31:0]   m_inst_addr;
    logic          out_valid;
    logic          out_ready;
    logic          out_kind;
    logic [31:0]   out_pc;
    logic [31:0]   out_addr;
    logic [31:0]   out_data;
    logic [3:0]    out_byteen;
    logic [CW-1:0] count;
    logic          overflow;
    logic [15:0]   dropped_cnt;

    modport slave (
        input  w_grf_we, w_grf_addr, w_grf_wdata, w_inst_addr,
        input  m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr,
        input  out_ready,
        output out_valid, out_kind, out_pc, out_addr, out_data, out_byteen,
        output count, overflow, dropped_cnt
    );

    modport master (
        output w_grf_we, w_grf_addr, w_grf_wdata, w_inst_addr,
        output m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr,
        output out_ready,
        input  out_valid, out_kind, out_pc, out_addr, out_data, out_byteen,
        input  count, overflow, dropped_cnt
    );
endinterface

// File: rtl/commit_trace_fifo.sv
// Commit-trace capture buffer: filters W-stage register writes and M-stage stores
// into trace records, queues up to two per cycle, drains one per cycle via valid/ready.
module commit_trace_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    commit_trace_fifo_if.slave   io_trace
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  byteen;
    } rec_t;

    rec_t          r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic [15:0]   r_dropped_cnt;

    logic          w_grf_ev;
    logic          w_mem_ev;
    logic          w_pop;
    logic [CW-1:0] w_free;
    logic [1:0]    w_push_n;
    logic [1:0]    w_drop_n;
    logic [16:0]   w_drop_sum;
    rec_t          w_rec_grf;
    rec_t          w_rec_mem;
    rec_t          w_rec0;

    assign w_grf_ev = io_trace.w_grf_we && (io_trace.w_grf_addr != 5'd0) && !i_reset;
    assign w_mem_ev = (|io_trace.m_data_byteen) && !i_reset;
    assign w_pop    = (r_count != '0) && io_trace.out_ready;
    // A pop in this cycle releases its slot to this cycle's pushes.
    assign w_free   = CW'(DEPTH) - r_count + CW'(w_pop);

    assign w_rec_grf = '{kind: 1'b0, pc: io_trace.w_inst_addr,
                         addr: {27'd0, io_trace.w_grf_addr},
                         data: io_trace.w_grf_wdata, byteen: 4'b1111};
    assign w_rec_mem = '{kind: 1'b1, pc: io_trace.m_inst_addr,
                         addr: io_trace.m_data_addr & 32'hFFFF_FFFC,
                         data: io_trace.m_data_wdata, byteen: io_trace.m_data_byteen};
    assign w_rec0    = w_grf_ev ? w_rec_grf : w_rec_mem;

    // The older W-stage record always wins the last free slot.
    always_comb begin
        w_push_n = 2'd0;
        w_drop_n = 2'd0;
        if (w_grf_ev && w_mem_ev) begin
            if (w_free >= CW'(2)) begin
                w_push_n = 2'd2;
            end else if (w_free == CW'(1)) begin
                w_push_n = 2'd1;
                w_drop_n = 2'd1;
            end else begin
                w_drop_n = 2'd2;
            end
        end else if (w_grf_ev || w_mem_ev) begin
            if (w_free != '0) begin
                w_push_n = 2'd1;
            end else begin
                w_drop_n = 2'd1;
            end
        end
    end

    assign w_drop_sum = {1'b0, r_dropped_cnt} + 17'(w_drop_n);

    always_ff @(posedge i_clk) begin
        if (w_push_n != 2'd0) begin
            r_mem[r_wr_ptr] <= w_rec0;
        end
        if (w_push_n == 2'd2) begin
            r_mem[r_wr_ptr + AW'(1)] <= w_rec_mem;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_overflow    <= 1'b0;
            r_dropped_cnt <= 16'd0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_push_n);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_count  <= r_count + CW'(w_push_n) - CW'(w_pop);
            if (w_drop_n != 2'd0) begin
                r_overflow    <= 1'b1;
                r_dropped_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            end
        end
    end

    assign io_trace.out_valid   = (r_count != '0);
    assign io_trace.out_kind    = r_mem[r_rd_ptr].kind;
    assign io_trace.out_pc      = r_mem[r_rd_ptr].pc;
    assign io_trace.out_addr    = r_mem[r_rd_ptr].addr;
    assign io_trace.out_data    = r_mem[r_rd_ptr].data;
    assign io_trace.out_byteen  = r_mem[r_rd_ptr].byteen;
    assign io_trace.count       = r_count;
    assign io_trace.overflow    = r_overflow;
    assign io_trace.dropped_cnt = r_dropped_cnt;
endmodule

// File: doc/commit_trace_fifo.md
# commit_trace_fifo

Commit-trace capture buffer that sits directly downstream of the `mips` core's retirement ports. It consumes the W-stage register-write port (`w_grf_*`, `w_inst_addr`) and the M-stage data-store port (`m_data_*`, `m_inst_addr`), and filters out events that are not architectural writes. Surviving events are packed into trace records and queued in a dual-push FIFO. Records drain over a valid/ready interface to a checker or logger, so the core is never back-pressured; overflow is flagged and counted instead.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, ≥ 4.
- `CW`, `$clog2(DEPTH)+1`, width of `count`.

- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `w_grf_we` in 1: W-stage register write enable.
- `w_grf_addr` in 5: destination register.
- `w_grf_wdata` in 32: value written to the register.
- `w_inst_addr` in 32: PC of the W-stage instruction.
- `m_data_addr` in 32: store byte address.
- `m_data_wdata` in 32: store data, lane-aligned.
- `m_data_byteen` in 4: store byte enables.
- `m_inst_addr` in 32: PC of the M-stage instruction.
- `out_valid` out 1: a record is at the FIFO head.
- `out_ready` in 1: consumer accepts the head record.
- `out_kind` out 1: record type; 0 = register write, 1 = memory write.
- `out_pc` out 32: PC of the recorded instruction.
- `out_addr` out 32: register number zero-extended (kind 0), or `m_data_addr & 32'hFFFF_FFFC` (kind 1).
- `out_data` out 32: `w_grf_wdata` (kind 0) or `m_data_wdata` (kind 1).
- `out_byteen` out 4: `4'b1111` (kind 0) or `m_data_byteen` (kind 1).
- `count` out CW: number of occupied entries.
- `overflow` out 1: sticky; set when any record is dropped.
- `dropped_cnt` out 16: number of dropped records; saturates at 16'hFFFF.

## Operation
- **GRF event:** `w_grf_we && w_grf_addr != 0 && !reset`. Writes to `$0` are never recorded.
- **MEM event:** `|m_data_byteen && !reset`.
- **Same-cycle events:** both may occur in one cycle. The GRF record is pushed before the MEM record, because the W-stage instruction is older.
- **Pop:** `pop = out_valid && out_ready`.
- **Free space:** `free = DEPTH - count + pop`. A pop frees its slot for use in the same cycle.
- **Push allocation:**
  - One event: pushed if `free ≥ 1`, otherwise dropped.
  - Two events, `free ≥ 2`: both pushed.
  - Two events, `free == 1`: GRF record pushed, MEM record dropped.
  - Two events, `free == 0`: both dropped.
- **Per drop:** `overflow ← 1`; `dropped_cnt` increments by the number of records dropped that cycle, saturating.
- **Storage:** circular buffer with pointers `wr_ptr` and `rd_ptr`, each modulo DEPTH. A second push writes to `wr_ptr+1`; pointers wrap naturally.
- **Count update:** `count_next = count + pushes - pop`, always in 0..DEPTH.
- **Output path:** the `out_*` fields are read combinationally from the entry at `rd_ptr`. `out_valid = (count != 0)`.
- **Valid/ready rules:**
  - While `out_valid && !out_ready`, the head record and all `out_*` fields are held stable.
  - `out_ready` asserted while `out_valid` is 0 has no effect.
- **Reset:** clears `wr_ptr`, `rd_ptr`, `count`, `overflow` and `dropped_cnt`. Storage contents are don't-care.
  - A reset asserted mid-stream discards all queued records.
  - Events presented during a reset cycle are ignored.

## Timing
- **Reset values:** `out_valid` = 0, `count` = 0, `overflow` = 0, `dropped_cnt` = 0. The `out_*` data fields are don't-care while `out_valid` = 0.
- **Push latency:** an event sampled at edge N makes `out_valid` = 1 (if the FIFO was empty) and updates `count` after edge N. This is one cycle of latency; there is no bypass.
- **Drain rate:** at most one pop per cycle. Push rate is at most two per cycle.
- **Full FIFO with pop:** when `count == DEPTH`, an event arriving in the same cycle as a pop is accepted (one slot), with no drop.
- **Flag timing:** `overflow` and `dropped_cnt` update at the same edge as the drop decision.

## Test plan
- **Dual event:** after reset, one cycle with `w_grf_we=1`, addr=5, wdata=32'h1234, PC=32'h3000 together with `m_data_byteen=4'b0011`, addr=32'h0006, wdata=32'h0000_BEEF, PC=32'h3004.
  - Expected: `count`=2.
  - First record: kind 0, addr 5, data 32'h1234, byteen 4'hF.
  - Second record: kind 1, addr 32'h4, byteen 4'b0011.
- **Filtering:** write to `$0` and a store with byteen 0 → no records, `count` stays 0.
- **Overflow:** DEPTH=16 with `out_ready`=0.
  - Stimulus: 8 dual-event cycles (16 records), then 1 dual-event cycle.
  - Expected: `count`=16, `overflow`=1, `dropped_cnt`=2. The head is still the first GRF record.
- **Pop with partial space:** `count`=15, dual event plus pop in the same cycle → `free`=2, both pushed, `count`=16, no drop.
- **Wrap-around and throughput:** with `out_ready`=1, 40 single GRF events with wdata=i.
  - Expected: records emerge in order with data 0..39.
  - Pointers wrap at least twice; `count` never exceeds 1.
- **Reset mid-stream:** reset asserted with `count`=7 and an event present in the same cycle → all outputs return to reset values; the event is not recorded.
